// File: rtl/regfile_multiport_if.sv
// Register file access bundle: one write port, NUM_READ packed read ports, clear control and status.
// The master drives requests and addresses; the slave (the register file) returns read data and status.
interface regfile_multiport_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic                           write_enable_flag;
    logic [ADDR_WIDTH-1:0]          wa;
    logic [DATA_WIDTH-1:0]          wd;
    logic [NUM_READ*ADDR_WIDTH-1:0] ra;
    logic [NUM_READ*DATA_WIDTH-1:0] rd;
    logic                           clear_req;
    logic                           busy;
    logic                           wr_dropped;

    modport master (
        output write_enable_flag, wa, wd, ra, clear_req,
        input  rd, busy, wr_dropped
    );

    modport slave (
        input  write_enable_flag, wa, wd, ra, clear_req,
        output rd, busy, wr_dropped
    );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-read-port register file, entry 0 hardwired to zero, with a clear sequencer run on reset or clear_req.
// Reads are combinational; writes land on the rising edge. REGFILE_BYPASS_EN adds same-cycle write forwarding.
// No backpressure: writes arriving while clearing (or alongside clear_req) are dropped and flagged in wr_dropped.
module regfile_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic                clk,
    input  logic                rst,
    regfile_multiport_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_idx, clr_idx_nxt;
    logic                    wr_dropped_q;
    logic                    drop_set;
    logic                    wr_req;
    logic                    wr_live;
    logic                    busy;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_arr [NUM_READ];

    assign busy           = (state == CLEAR);
    assign bus.busy       = busy;
    assign bus.wr_dropped = wr_dropped_q;
    assign wr_req         = bus.write_enable_flag && (bus.wa != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CLEAR;
            clr_idx      <= FIRST_IDX;
            wr_dropped_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
            if (drop_set) begin
                wr_dropped_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        wr_live     = 1'b0;
        drop_set    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    state_nxt   = CLEAR;
                    clr_idx_nxt = FIRST_IDX;
                    drop_set    = wr_req;
                end else begin
                    wr_live = wr_req;
                end
            end
            CLEAR: begin
                // clear_req is not looked at here, so a request while busy never restarts the sweep
                drop_set = wr_req;
                if (clr_idx == LAST_IDX) begin
                    state_nxt = IDLE;
                end else begin
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_idx_nxt = FIRST_IDX;
            end
        endcase
    end

    // Storage has no reset; the sweep above zeroes entries 1..DEPTH-1, entry 0 is never read
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_live) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_g;
        assign ra_g = bus.ra[g*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_arr[g] = '0;
            if (!busy && (ra_g != '0)) begin
                rd_arr[g] = mem[ra_g];
`ifdef REGFILE_BYPASS_EN
                if (bus.write_enable_flag && !bus.clear_req && (bus.wa == ra_g)) begin
                    rd_arr[g] = bus.wd;
                end
`endif
            end
        end
    end

    always_comb begin
        bus.rd = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            bus.rd[i*DATA_WIDTH +: DATA_WIDTH] = rd_arr[i];
        end
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed scenarios plus random traffic checked against an array model.
module tb_regfile_multiport;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_multiport_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

    regfile_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: contents as software sees them, edges left in the current clear, sticky drop flag
    logic [DW-1:0] ref_mem [DEPTH];
    int            remain;
    bit            ref_drop;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (remain > 0 || a == '0) return '0;
        if (BYP && bus.write_enable_flag && !bus.clear_req && bus.wa == a) return bus.wd;
        return ref_mem[a];
    endfunction

    task automatic model_edge();
        bit wr_req;
        if (rst) return;
        wr_req = bus.write_enable_flag && (bus.wa != '0);
        if (remain > 0) begin
            if (wr_req) ref_drop = 1'b1;
            remain--;
        end else if (bus.clear_req) begin
            if (wr_req) ref_drop = 1'b1;
            foreach (ref_mem[i]) ref_mem[i] = '0;
            remain = DEPTH - 1;
        end else if (wr_req) begin
            ref_mem[bus.wa] = bus.wd;
        end
    endtask

    // Check every output against the model, then advance one edge
    task automatic cyc();
        #2;
        chk("busy", DW'(bus.busy), DW'(remain > 0));
        chk("wr_dropped", DW'(bus.wr_dropped), DW'(ref_drop));
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("rd%0d", p), bus.rd[p*DW +: DW], exp_rd(bus.ra[p*AW +: AW]));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic cr);
        bus.write_enable_flag = we;
        bus.wa                = a;
        bus.wd                = d;
        bus.clear_req         = cr;
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        bus.ra[p*AW +: AW] = a;
    endtask

    task automatic rand_ra();
        for (int p = 0; p < NR; p++) set_ra(p, AW'($urandom_range(DEPTH - 1)));
    endtask

    task automatic do_rst(input int n);
        rst      = 1'b1;
        remain   = DEPTH - 1;
        ref_drop = 1'b0;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, '0, '0, 1'b0);
        bus.ra = '0;
        do_rst(3);

        // Clear after reset release: reads zero, busy for exactly DEPTH-1 edges
        for (int i = 0; i < DEPTH - 1; i++) begin
            rand_ra();
            cyc();
        end
        chk("busy_after_clear", DW'(bus.busy), '0);
        for (int a = 0; a < DEPTH; a++) begin
            set_ra(0, AW'(a));
            set_ra(1, AW'(DEPTH - 1 - a));
            cyc();
        end

        // Basic write / dual-port read, then a write to address 0
        set_in(1'b1, AW'(5), 32'hDEADBEEF, 1'b0);
        cyc();
        set_in(1'b0, '0, '0, 1'b0);
        set_ra(0, AW'(5));
        set_ra(1, AW'(5));
        #1;
        chk("rd0_deadbeef", bus.rd[0 +: DW], 32'hDEADBEEF);
        chk("rd1_deadbeef", bus.rd[DW +: DW], 32'hDEADBEEF);
        cyc();
        set_in(1'b1, '0, 32'h1234, 1'b0);
        cyc();
        set_in(1'b0, '0, '0, 1'b0);
        set_ra(0, '0);
        #1;
        chk("rd_addr0", bus.rd[0 +: DW], '0);
        chk("drop_addr0", DW'(bus.wr_dropped), '0);
        cyc();

        // Write while busy is dropped and the flag sticks
        set_in(1'b0, '0, '0, 1'b1);
        cyc();
        set_in(1'b1, AW'(7), 32'h0BAD0BAD, 1'b0);
        cyc();
        set_in(1'b0, '0, '0, 1'b0);
        repeat (DEPTH - 2) cyc();
        set_ra(0, AW'(7));
        #1;
        chk("busy_done2", DW'(bus.busy), '0);
        chk("rd_entry7", bus.rd[0 +: DW], '0);
        chk("drop_busy", DW'(bus.wr_dropped), 32'd1);
        cyc();

        // Load everything, then clear_req together with a write
        for (int a = 1; a < DEPTH; a++) begin
            set_in(1'b1, AW'(a), $urandom, 1'b0);
            rand_ra();
            cyc();
        end
        set_in(1'b1, AW'(3), 32'h77, 1'b1);
        cyc();
        set_in(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            rand_ra();
            cyc();
        end
        for (int a = 0; a < DEPTH; a++) begin
            set_ra(0, AW'(a));
            set_ra(1, AW'(a));
            cyc();
        end

        // Read during write, with and without forwarding
        set_in(1'b1, AW'(9), 32'h11, 1'b0);
        cyc();
        set_in(1'b1, AW'(9), 32'hA5A5A5A5, 1'b0);
        set_ra(0, AW'(9));
        #1;
        chk("rdw_same", bus.rd[0 +: DW], BYP ? 32'hA5A5A5A5 : 32'h11);
        cyc();
        set_in(1'b0, '0, '0, 1'b0);
        #1;
        chk("rdw_next", bus.rd[0 +: DW], 32'hA5A5A5A5);

        // Reset in the middle of a clear restarts the full sweep
        set_in(1'b0, '0, '0, 1'b1);
        cyc();
        set_in(1'b0, '0, '0, 1'b0);
        repeat (9) cyc();
        do_rst(2);
        for (int i = 0; i < DEPTH - 1; i++) begin
            rand_ra();
            cyc();
        end
        chk("busy_after_rst_restart", DW'(bus.busy), '0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            set_in(1'($urandom_range(1)), AW'($urandom_range(DEPTH - 1)), $urandom,
                   1'($urandom_range(99) == 0));
            rand_ra();
            if ($urandom_range(499) == 0) do_rst(1 + $urandom_range(2));
            else cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised successor to the core's integer register file.
- Configurable data width, depth and number of combinational read ports.
- Entry 0 hardwired to zero.
- Asynchronous reset starts a hardware clear sequencer that zeroes every entry, so no initial-block preload is needed.
- Sits in the decode stage of the RISC-V datapath, feeding ALU operands and accepting writeback.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries
NUM_READ, 2, number of independent read ports (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
write_enable_flag  input  1  write request for this cycle
wa  input  ADDR_WIDTH  write address
wd  input  DATA_WIDTH  write data
ra  input  NUM_READ*ADDR_WIDTH  packed read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rd  output  NUM_READ*DATA_WIDTH  packed read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
clear_req  input  1  pulse: request a full software-initiated clear
busy  output  1  high while the clear sequencer runs
wr_dropped  output  1  sticky flag: a write was discarded

Behaviour:
- Reset is asynchronous and active-high; clock is clk, reset is rst.
- On rst assertion:
  - state=CLEAR, clr_idx=1, busy=1, wr_dropped=0.
  - Array contents are not reset directly; the sequencer zeroes them.
- FSM states:
  - IDLE:
    - clear_req=1 -> CLEAR, clr_idx<=1.
    - Otherwise a write with write_enable_flag=1 and wa!=0 updates entry wa at the edge.
  - CLEAR:
    - Each edge writes entry clr_idx <= 0.
    - If clr_idx==DEPTH-1 -> IDLE, else clr_idx++.
- Clear duration: DEPTH-1 rising edges after rst release or after the clear_req edge (31 at defaults). busy is combinational from state (high iff CLEAR).
- Writes during CLEAR, or in the IDLE cycle where clear_req=1, are discarded and set wr_dropped=1. The flag stays set until rst.
- Writes to address 0 are silently ignored and do not set wr_dropped.
- clear_req while busy is ignored; it does not restart the sequence.
- Read ports are combinational and independent; any number may alias the same address.
- Reads while busy return 0 on all ports.
- Reads of address 0 always return 0.
- Read-during-write to the same address without the optional feature: rd returns the old value; the new value is visible the cycle after the edge.
- rst mid-clear restarts the sequence from clr_idx=1.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: write-through forwarding. For each port i, if write_enable_flag=1, busy=0, clear_req=0, wa!=0 and ra_i==wa, then rd_i = wd in the same cycle.
- Not defined: no forwarding; read-during-write returns the pre-write value.

Test Plan:
- Release rst, check reads during clear -> busy=1 for exactly 31 edges at defaults and all rd=0; busy=0 after the 31st edge; every entry 1..31 reads 0.
- After clear, write 0xDEADBEEF to wa=5, next cycle ra0=5 and ra1=5 -> both rd ports read 0xDEADBEEF; write 0x1234 to wa=0 -> ra0=0 reads 0 and wr_dropped=0.
- Assert write_enable_flag with wa=7 while busy=1 -> entry 7 reads 0 after clear and wr_dropped=1; the flag stays 1 until rst.
- In IDLE with entries 1..31 loaded, pulse clear_req together with a write to wa=3 -> write dropped, busy high for 31 edges, all entries read 0 afterwards, wr_dropped=1.
- Same-cycle write wa=9 wd=0xA5A5A5A5 and read ra0=9 (entry holds 0x11) -> rd0=0x11 without REGFILE_BYPASS_EN, 0xA5A5A5A5 with it; next cycle 0xA5A5A5A5 in both builds.
- Assert rst when clr_idx=10 during a clear -> busy stays 1 and clearing restarts at clr_idx=1, taking 31 more edges after release.
